// File: rtl/universal_shift_register_if.sv
// -----------------------------------------------------------------------------
// universal_shift_register_if
//
// Groups the data/control bus of the universal shift register.
//
// Signals:
//   msb_in  serial bit entering the top of the register on a right shift
//   lsb_in  serial bit entering the bottom of the register on a left shift
//   p_in    parallel load data, N bits
//   select  operation code: 00 hold, 01 shift right, 10 shift left, 11 load
//   p_out   current register contents, N bits
//
// Modports:
//   master  the block that drives the register (stimulus / upstream logic)
//   slave   the shift register itself
// -----------------------------------------------------------------------------
interface universal_shift_register_if #(
  parameter int N = 4
);
  logic         msb_in;
  logic         lsb_in;
  logic [N-1:0] p_in;
  logic [1:0]   select;
  logic [N-1:0] p_out;

  modport master (
    output msb_in,
    output lsb_in,
    output p_in,
    output select,
    input  p_out
  );

  modport slave (
    input  msb_in,
    input  lsb_in,
    input  p_in,
    input  select,
    output p_out
  );
endinterface

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// N-bit register that, on every rising clock edge, holds, shifts right, shifts
// left or loads in parallel according to a 2-bit select. The register is
// driven straight onto p_out, so there is no combinational input-to-output
// path.
//
// Parameters:
//   N            register width in bits (N >= 2)
//   RESET_VALUE  contents forced while reset is high
//
// Ports:
//   clk    input   sole clock, rising-edge active
//   reset  input   asynchronous, active-high; forces the register to
//                  RESET_VALUE immediately and dominates every select value
//   bus    slave   msb_in, lsb_in, p_in, select in; p_out out
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int         N           = 4,
  parameter logic [N-1:0] RESET_VALUE = {N{1'b0}}
) (
  input  logic                          clk,
  input  logic                          reset,
  universal_shift_register_if.slave     bus
);

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_SHR   = 2'b01,
    OP_SHL   = 2'b10,
    OP_LOAD  = 2'b11
  } op_e;

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;
  op_e          op;

  assign op = op_e'(bus.select);

  // Next-state selection. Inputs not used by the chosen operation are simply
  // not referenced in that branch, so they cannot disturb the result.
  always_comb begin
    q_d = q_q;
    unique case (op)
      OP_HOLD: q_d = q_q;
      OP_SHR:  q_d = {bus.msb_in, q_q[N-1:1]};
      OP_SHL:  q_d = {q_q[N-2:0], bus.lsb_in};
      OP_LOAD: q_d = bus.p_in;
      default: q_d = q_q;
    endcase
  end

  // State register: reset is asynchronous so the output snaps to
  // RESET_VALUE without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign bus.p_out = q_q;

endmodule

// File: tb/tb_universal_shift_register.sv
module tb_universal_shift_register;

  localparam int N    = 4;
  localparam int MODV = 1 << N;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;
  int   model;   // reference register contents as a plain integer

  universal_shift_register_if #(.N(N)) bus ();

  universal_shift_register #(
    .N(N),
    .RESET_VALUE({N{1'b0}})
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural rule set: right shift halves and injects msb_in as the
  // top weight, left shift doubles, adds lsb_in and wraps modulo 2^N.
  function automatic int next_model(int cur, int sel, int msb, int lsb, int pin);
    case (sel)
      1:       return (cur / 2) + (msb * (MODV / 2));
      2:       return ((cur * 2) + lsb) % MODV;
      3:       return pin;
      default: return cur;
    endcase
  endfunction

  // Advance one clock edge, update the model from the inputs present at the
  // edge, then move 1 time unit past the edge for sampling.
  task automatic tick();
    @(posedge clk);
    if (!reset)
      model = next_model(model, int'(bus.select), int'(bus.msb_in), int'(bus.lsb_in), int'(bus.p_in));
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic msb, input logic lsb, input logic [N-1:0] pin);
    bus.select = sel;
    bus.msb_in = msb;
    bus.lsb_in = lsb;
    bus.p_in   = pin;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model = 0;
    drive(2'b11, 1'b1, 1'b1, 4'b0110);
    #2;
    vectors++;
    if (bus.p_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_initial got %b expected 0000", bus.p_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bus.p_out !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_held cycle %0d got %b expected 0000", i, bus.p_out);
      end
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (bus.p_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_release_no_change got %b expected 0000", bus.p_out);
    end
    tick();
    vectors++;
    if (bus.p_out !== 4'b0110 || int'(bus.p_out) != model) begin
      miscompares++;
      $display("FAIL reset_first_load got %b expected 0110 (model %0d)", bus.p_out, model);
    end
  endtask

  task automatic test_hold();
    drive(2'b11, 1'b0, 1'b0, 4'b1010);
    tick();
    vectors++;
    if (bus.p_out !== 4'b1010) begin
      miscompares++;
      $display("FAIL hold_preload got %b expected 1010", bus.p_out);
    end
    for (int i = 0; i < 10; i++) begin
      drive(2'b00, 1'($urandom), 1'($urandom), N'($urandom));
      tick();
      vectors++;
      if (bus.p_out !== 4'b1010 || int'(bus.p_out) != model) begin
        miscompares++;
        $display("FAIL hold cycle %0d got %b expected 1010", i, bus.p_out);
      end
    end
  endtask

  task automatic test_shift_right();
    logic [3:0] msb_seq = 4'b0011;   // applied bit 3 first: 1,1,0,0 reversed below
    logic [N-1:0] exp_tab [4] = '{4'b1101, 4'b1110, 4'b0111, 4'b0011};
    logic bits [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    msb_seq = 4'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, bits[i], 1'(i), N'($urandom));
      tick();
      vectors++;
      if (bus.p_out !== exp_tab[i] || int'(bus.p_out) != model) begin
        miscompares++;
        $display("FAIL shift_right step %0d got %b expected %b", i, bus.p_out, exp_tab[i]);
      end
    end
    msb_seq = msb_seq;
  endtask

  task automatic test_shift_left();
    logic [N-1:0] exp_tab [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};
    logic bits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 1'($urandom), bits[i], N'($urandom));
      tick();
      vectors++;
      if (bus.p_out !== exp_tab[i] || int'(bus.p_out) != model) begin
        miscompares++;
        $display("FAIL shift_left step %0d got %b expected %b", i, bus.p_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [N-1:0] data_tab [3] = '{4'b1001, 4'b0110, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'($urandom), 1'($urandom), data_tab[i]);
      tick();
      vectors++;
      if (bus.p_out !== data_tab[i]) begin
        miscompares++;
        $display("FAIL load step %0d got %b expected %b", i, bus.p_out, data_tab[i]);
      end
    end
    // Asynchronous reset between edges must clear the register at once.
    #2 reset = 1'b1;
    model = 0;
    #1;
    vectors++;
    if (bus.p_out !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset_midcycle got %b expected 0000", bus.p_out);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_mixed();
    logic [1:0]   sel_tab [4] = '{2'b11, 2'b01, 2'b10, 2'b00};
    logic         msb_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic         lsb_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] exp_tab [4] = '{4'b0101, 4'b1010, 4'b0100, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      drive(sel_tab[i], msb_tab[i], lsb_tab[i], (i == 0) ? 4'b0101 : N'($urandom));
      tick();
      vectors++;
      if (bus.p_out !== exp_tab[i] || int'(bus.p_out) != model) begin
        miscompares++;
        $display("FAIL mixed step %0d got %b expected %b", i, bus.p_out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom), 1'($urandom), 1'($urandom), N'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        #1 reset = 1'b1;
        model = 0;
        #1;
        vectors++;
        if (int'(bus.p_out) != model) begin
          miscompares++;
          $display("FAIL random_reset iter %0d got %b expected %0d", i, bus.p_out, model);
        end
        reset = 1'b0;
      end
      tick();
      vectors++;
      if (int'(bus.p_out) != model) begin
        miscompares++;
        $display("FAIL random iter %0d sel %b got %b expected %0d", i, bus.select, bus.p_out, model);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Load a walking pattern then rotate through shifts each cycle with
    // select changing every edge.
    drive(2'b11, 1'b0, 1'b0, 4'b1000);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive((i % 2 == 0) ? 2'b01 : 2'b10, 1'(i % 3 == 0), 1'(i % 2 == 0), 4'b1111);
      tick();
      vectors++;
      if (int'(bus.p_out) != model) begin
        miscompares++;
        $display("FAIL back_to_back step %0d got %b expected %0d", i, bus.p_out, model);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model       = 0;
    reset       = 1'b1;
    drive(2'b00, 1'b0, 1'b0, '0);
    test_reset();
    test_hold();
    test_shift_right();
    test_shift_left();
    test_load();
    test_mixed();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- N-bit universal shift register: hold, shift right, shift left, or parallel load on each clock edge, chosen by a 2-bit select.
- Generic datapath building block for serial/parallel conversion and bit-stream alignment.
- Register contents are always visible on a parallel output.

Parameters:
- N, 4, register width in bits (N >= 2).
- RESET_VALUE, {N{1'b0}}, value loaded into the register on reset.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset; forces register to RESET_VALUE.
- msb_in  input  1  serial input entering bit N-1 during shift right.
- lsb_in  input  1  serial input entering bit 0 during shift left.
- p_in  input  N  parallel load data.
- select  input  2  operation select (encoding below).
- p_out  output  N  current register contents, driven directly from the register (no combinational path from inputs).

Behaviour:
- Internal state: one N-bit register q; p_out = q at all times.
- Reset:
  - While reset = 1, q = RESET_VALUE immediately, independent of clk.
  - reset dominates every select value.
  - Deasserting reset does not change q; the first update occurs at the next rising clk edge with reset = 0.
  - Reset asserted mid-sequence discards the contents; operation resumes from RESET_VALUE.
- On each rising clk edge with reset = 0:
  - select = 00 hold: q <= q.
  - select = 01 shift right: q <= {msb_in, q[N-1:1]}; q[0] is discarded.
  - select = 10 shift left: q <= {q[N-2:0], lsb_in}; q[N-1] is discarded.
  - select = 11 parallel load: q <= p_in.
- Timing and sampling:
  - Latency is one clock: the result appears on p_out after the edge that samples select/data.
  - Inputs not used by the current operation are ignored (e.g. lsb_in during shift right, p_in during shifts).
  - select may change every cycle; each edge acts only on the select value present at that edge.
- No X-propagation requirements beyond standard RTL semantics. All four select codes are defined; there is no illegal state.
- No enable, no overflow/flag outputs. Bits shifted out are lost.

Test Plan:
- Reset: assert reset with select = 11, p_in = 0110, clock running -> p_out = 0000 throughout reset. Release reset and apply select = 11 -> p_out = 0110 after the next rising edge.
- Hold: load 1010, then select = 00 for 10 cycles with random p_in, msb_in, lsb_in -> p_out stays 1010 every cycle.
- Shift right: from 1010, select = 01 with msb_in sequence 1, 1, 0, 0 -> p_out = 1101, 1110, 0111, 0011. lsb_in and p_in toggling have no effect.
- Shift left: from 0011, select = 10 with lsb_in sequence 1, 0, 1, 1 -> p_out = 0111, 1110, 1101, 1011. msb_in has no effect.
- Parallel load: select = 11 with p_in = 1001, 0110, 1111 on consecutive edges -> p_out follows with one-cycle latency. Then assert reset between clock edges -> p_out goes to 0000 immediately, before the next edge.
- Mixed: change select every cycle (11 load 0101, 01 msb_in = 1, 10 lsb_in = 0, 00) -> p_out = 0101, 1010, 0100, 0100.
